fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage between the PC register and the decode stage. Takes the current PC, issues a single-outstanding request to a variable-latency instruction memory, and holds the returned word with its PC for decode under a valid/ready handshake. Produces the one-cycle `pc_advance` pulse that gates PC register updates, so the PC moves only when an instruction has been consumed. Supports redirect flushes and flags misaligned PCs.

## Interface
- `WIDTH`, 32, width of PC, address, instruction and counter
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `pc`  in  WIDTH  current PC from the PC register
- `flush`  in  1  PC register redirected this cycle; discard all in-flight work
- `imem_req`  out  1  one-cycle request pulse; memory accepts every request
- `imem_addr`  out  WIDTH  request address, valid while `imem_req`=1
- `imem_rvalid`  in  1  response valid (≥1 cycle after request)
- `imem_rdata`  in  WIDTH  response data
- `instr_valid`  out  1  `instr`/`instr_pc` hold a valid instruction
- `instr_ready`  in  1  decode accepts
- `instr`  out  WIDTH  fetched instruction
- `instr_pc`  out  WIDTH  PC of `instr`
- `pc_advance`  out  1  one-cycle pulse; PC register loads next PC
- `fetch_fault`  out  1  `pc[1:0]`≠0 while in IDLE
- `fetch_count`  out  WIDTH  instructions delivered to decode since reset

## Operation
- FSM states: IDLE, WAIT, DROP, HOLD. Reset state IDLE.
- IDLE:
  - `flush`=1: no request; stay IDLE.
  - `pc[1:0]`≠0: no request; `fetch_fault`=1 (combinational); stay IDLE.
  - otherwise: `imem_req`=1, `imem_addr`=`pc`; latch `pc` into the request-address register; go WAIT.
- WAIT:
  - `imem_rvalid`=1 and `flush`=0: `instr`<=`imem_rdata`, `instr_pc`<=latched address; go HOLD.
  - `imem_rvalid`=1 and `flush`=1: drop the data; go IDLE.
  - `imem_rvalid`=0 and `flush`=1: go DROP.
  - otherwise: stay WAIT.
- DROP: wait for `imem_rvalid`, discard the data, go IDLE. A `flush` in DROP has no further effect.
- HOLD: `instr_valid`=1.
  - `flush`=1: go IDLE, no `pc_advance`. Flush wins over a same-cycle `instr_ready`.
  - `instr_ready`=1: `pc_advance`=1 for this cycle; `fetch_count` increments; go IDLE.
  - otherwise: stay HOLD. `instr` and `instr_pc` are stable.
- `instr_valid` is a registered decode of state==HOLD. `pc_advance`=HOLD & `instr_ready` & ~`flush` (combinational).
- `imem_rvalid` is ignored in IDLE and HOLD.
- `fetch_count` wraps modulo 2^WIDTH.
- At most one request is outstanding at any time.

## Timing
- Reset values: state IDLE; `imem_req`, `instr_valid`, `pc_advance`, `fetch_fault` = 0; `instr`, `instr_pc`, `imem_addr`, `fetch_count` = 0. The first request issues in the first cycle after `rst` deasserts, if `pc` is aligned.
- With memory latency L (rvalid L cycles after req, L≥1): req at cycle t, `instr_valid`=1 from t+L+1.
- `pc_advance` at cycle h advances the PC at h+1; the next request issues at h+1.
- Throughput: one instruction per L+2 cycles when `instr_ready` is held at 1.
- Reset mid-WAIT or mid-DROP: return to IDLE. A stale `imem_rvalid` arriving afterwards in IDLE or HOLD is ignored.

## Test plan
- Basic fetch, L=1, `instr_ready`=1: `pc`=0x0 at reset release, memory returns 0x00500093. Required: req at cycle 0 with addr 0x0; `instr_valid`=1 and `instr`=0x00500093, `instr_pc`=0x0 at cycle 2; `pc_advance` at cycle 2; next req with addr 0x4 at cycle 3.
- Back-pressure: `instr_ready`=0 for 5 cycles in HOLD. Required: `instr`/`instr_pc` stable, no `pc_advance`, `fetch_count` unchanged. Raising `instr_ready` gives one `pc_advance` and `fetch_count` +1.
- Flush in WAIT, L=4: assert `flush` 1 cycle after req. Required: DROP; the late response is discarded; `instr_valid` stays 0; a new req issues the cycle after rvalid, with the redirected `pc` (e.g. 0x40).
- Flush and `instr_ready` together in HOLD. Required: no `pc_advance`, no count increment; `instr_valid` is 0 the next cycle.
- Misaligned: `pc`=0x6 in IDLE. Required: `fetch_fault`=1 and no `imem_req` until `pc` becomes 0x8, then a normal req to 0x8.
- Reset mid-WAIT, then rvalid arrives after reset. Required: all outputs at reset values; the stale response is ignored; a fresh req issues.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage between the PC register and decode. It issues one
//   request at a time to a variable-latency instruction memory and holds the
//   returned word with its PC under a valid/ready handshake. It generates the
//   pc_advance pulse so the PC only moves once decode has consumed an
//   instruction. It also handles redirect flushes and flags misaligned PCs.
//
//   State table:
//     IDLE | ready to issue a request for the current pc
//     WAIT | request outstanding, response will be kept
//     DROP | request outstanding, response will be discarded (flushed)
//     HOLD | instruction presented to decode, waiting for instr_ready
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   pc                 current PC from the PC register
//   flush              redirect this cycle; discard in-flight work
//   imem_req/addr      one-cycle request pulse and its address
//   imem_rvalid/rdata  memory response
//   instr_valid/ready  decode handshake
//   instr, instr_pc    fetched word and its PC
//   pc_advance         one-cycle pulse telling the PC register to advance
//   fetch_fault        pc misaligned while idle
//   fetch_count        instructions delivered since reset (wraps)
module fetch_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc,
    input  logic             flush,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    output logic             pc_advance,
    output logic             fetch_fault,
    output logic [WIDTH-1:0] fetch_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DROP = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [WIDTH-1:0] req_addr;
    logic             aligned;

    assign aligned = (pc[1:0] == 2'b00);

    // Combinational outputs are gated by rst so they read as inactive for
    // the whole time reset is held, not only after the first reset edge.
    always_comb begin
        imem_req    = !rst && (state == IDLE) && !flush && aligned;
        imem_addr   = imem_req ? pc : '0;
        fetch_fault = !rst && (state == IDLE) && !aligned;
        pc_advance  = !rst && (state == HOLD) && instr_ready && !flush;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (imem_req) state_next = WAIT;
            WAIT: begin
                if (imem_rvalid && !flush)      state_next = HOLD;
                else if (imem_rvalid && flush)  state_next = IDLE;
                else if (flush)                 state_next = DROP;
            end
            DROP: if (imem_rvalid) state_next = IDLE;
            HOLD: if (flush || instr_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            instr_valid <= 1'b0;
            req_addr    <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            fetch_count <= '0;
        end else begin
            state       <= state_next;
            instr_valid <= (state_next == HOLD);
            if (imem_req)
                req_addr <= pc;
            if ((state == WAIT) && imem_rvalid && !flush) begin
                instr    <= imem_rdata;
                instr_pc <= req_addr;
            end
            if (pc_advance)
                fetch_count <= fetch_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Directed bench for fetch_unit. Each task drives one scenario cycle by
//   cycle, acting as the instruction memory itself, and compares outputs
//   against hand-computed values. Inputs change 2 time units after a rising
//   edge and outputs are sampled 1 unit later, well away from the next edge.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        pc_advance;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .pc_advance  (pc_advance),
        .fetch_fault (fetch_fault),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs may then be changed.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    // Hold reset for two edges, then release with the given pc and ready.
    // On return the DUT is in IDLE in "cycle 0" after reset release.
    task automatic apply_reset(input logic [31:0] p, input logic rdy);
        rst = 1'b1; flush = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        pc = p; instr_ready = rdy;
        tick();
        tick();
        rst = 1'b0;
        settle();
    endtask

    task automatic test_reset();
        rst = 1'b1; pc = 32'h0; flush = 1'b0; imem_rvalid = 1'b0;
        imem_rdata = '0; instr_ready = 1'b0;
        tick();
        tick();
        settle();
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_imem_req got %b exp 0", imem_req); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_imem_addr got %h exp 0", imem_addr); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_instr_valid got %b exp 0", instr_valid); end
        n_checks++; if (pc_advance !== 1'b0) begin n_fail++; $display("FAIL reset_pc_advance got %b exp 0", pc_advance); end
        n_checks++; if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fetch_fault got %b exp 0", fetch_fault); end
        n_checks++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h/%h exp 0/0", instr, instr_pc); end
        n_checks++; if (fetch_count !== 32'h0) begin n_fail++; $display("FAIL reset_fetch_count got %0d exp 0", fetch_count); end
    endtask

    task automatic test_basic_fetch();
        apply_reset(32'h0, 1'b1);
        // cycle 0: request to 0x0
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL basic_req0 got %b/%h exp 1/00000000", imem_req, imem_addr); end
        tick();
        // cycle 1: WAIT, memory answers (L=1)
        imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
        settle();
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL basic_no_req1 got %b exp 0", imem_req); end
        tick();
        // cycle 2: HOLD, consumed immediately
        imem_rvalid = 1'b0; imem_rdata = 32'h0;
        settle();
        n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b exp 1", instr_valid); end
        n_checks++; if (instr !== 32'h0050_0093) begin n_fail++; $display("FAIL basic_instr got %h exp 00500093", instr); end
        n_checks++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL basic_instr_pc got %h exp 0", instr_pc); end
        n_checks++; if (pc_advance !== 1'b1) begin n_fail++; $display("FAIL basic_pc_advance got %b exp 1", pc_advance); end
        tick();
        // cycle 3: PC register has advanced, next request
        pc = 32'h4;
        settle();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL basic_req3 got %b/%h exp 1/00000004", imem_req, imem_addr); end
        n_checks++; if (fetch_count !== 32'd1) begin n_fail++; $display("FAIL basic_count got %0d exp 1", fetch_count); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid3 got %b exp 0", instr_valid); end
    endtask

    task automatic test_backpressure();
        apply_reset(32'h100, 1'b0);
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL bp_req got %b/%h exp 1/00000100", imem_req, imem_addr); end
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h1111_2222;
        tick();
        imem_rvalid = 1'b0; imem_rdata = 32'hffff_ffff;
        for (int i = 0; i < 5; i++) begin
            settle();
            n_checks++;
            if (instr_valid !== 1'b1 || instr !== 32'h1111_2222 || instr_pc !== 32'h100 ||
                pc_advance !== 1'b0 || fetch_count !== 32'd0 || imem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d] got v=%b i=%h pc=%h adv=%b cnt=%0d req=%b exp 1/11112222/00000100/0/0/0",
                         i, instr_valid, instr, instr_pc, pc_advance, fetch_count, imem_req);
            end
            tick();
        end
        instr_ready = 1'b1;
        settle();
        n_checks++; if (pc_advance !== 1'b1) begin n_fail++; $display("FAIL bp_release_adv got %b exp 1", pc_advance); end
        tick();
        instr_ready = 1'b0;
        pc = 32'h104;
        settle();
        n_checks++; if (fetch_count !== 32'd1) begin n_fail++; $display("FAIL bp_count got %0d exp 1", fetch_count); end
        n_checks++; if (pc_advance !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL bp_after got adv=%b v=%b exp 0/0", pc_advance, instr_valid); end
    endtask

    task automatic test_flush_wait();
        apply_reset(32'h10, 1'b1);
        // cycle 0: request to 0x10
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin n_fail++; $display("FAIL fw_req got %b/%h exp 1/00000010", imem_req, imem_addr); end
        tick();
        // cycle 1: redirect to 0x40
        flush = 1'b1; pc = 32'h40;
        settle();
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL fw_req_on_flush got %b exp 0", imem_req); end
        tick();
        flush = 1'b0;
        // cycles 2,3: DROP, no response yet
        for (int i = 2; i < 4; i++) begin
            settle();
            n_checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL fw_drop[%0d] got req=%b v=%b exp 0/0", i, imem_req, instr_valid); end
            tick();
        end
        // cycle 4: late response (L=4) must be discarded
        imem_rvalid = 1'b1; imem_rdata = 32'hdead_beef;
        settle();
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL fw_req_at_rvalid got %b exp 0", imem_req); end
        tick();
        // cycle 5: back in IDLE, new request to the redirected pc
        imem_rvalid = 1'b0; imem_rdata = 32'h0;
        settle();
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL fw_valid got %b exp 0", instr_valid); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_fail++; $display("FAIL fw_newreq got %b/%h exp 1/00000040", imem_req, imem_addr); end
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
        tick();
        imem_rvalid = 1'b0;
        settle();
        n_checks++; if (instr_valid !== 1'b1 || instr !== 32'h1234_5678 || instr_pc !== 32'h40) begin n_fail++; $display("FAIL fw_refetch got v=%b i=%h pc=%h exp 1/12345678/00000040", instr_valid, instr, instr_pc); end
    endtask

    task automatic test_flush_hold();
        apply_reset(32'h20, 1'b1);
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'haaaa_5555;
        tick();
        // HOLD with flush and ready both high
        imem_rvalid = 1'b0;
        flush = 1'b1;
        settle();
        n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL fh_valid got %b exp 1", instr_valid); end
        n_checks++; if (pc_advance !== 1'b0) begin n_fail++; $display("FAIL fh_adv got %b exp 0", pc_advance); end
        tick();
        flush = 1'b0;
        settle();
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL fh_valid_next got %b exp 0", instr_valid); end
        n_checks++; if (fetch_count !== 32'd0) begin n_fail++; $display("FAIL fh_count got %0d exp 0", fetch_count); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin n_fail++; $display("FAIL fh_req got %b/%h exp 1/00000020", imem_req, imem_addr); end
    endtask

    task automatic test_misaligned();
        apply_reset(32'h6, 1'b1);
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (fetch_fault !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL mis_fault[%0d] got fault=%b req=%b exp 1/0", i, fetch_fault, imem_req); end
            tick();
            settle();
        end
        pc = 32'h8;
        settle();
        n_checks++; if (fetch_fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_fail++; $display("FAIL mis_aligned got fault=%b req=%b addr=%h exp 0/1/00000008", fetch_fault, imem_req, imem_addr); end
        tick();
        settle();
        n_checks++; if (imem_req !== 1'b0 || fetch_fault !== 1'b0) begin n_fail++; $display("FAIL mis_wait got req=%b fault=%b exp 0/0", imem_req, fetch_fault); end
    endtask

    task automatic test_reset_mid_wait();
        apply_reset(32'h30, 1'b1);
        tick();
        // cycle 1: WAIT, assert reset
        rst = 1'b1;
        tick();
        settle();
        n_checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc_advance !== 1'b0 || fetch_fault !== 1'b0 ||
            instr !== 32'h0 || instr_pc !== 32'h0 || imem_addr !== 32'h0 || fetch_count !== 32'h0) begin
            n_fail++;
            $display("FAIL rmw_reset got req=%b v=%b adv=%b flt=%b i=%h ipc=%h addr=%h cnt=%0d exp all 0",
                     imem_req, instr_valid, pc_advance, fetch_fault, instr, instr_pc, imem_addr, fetch_count);
        end
        // release reset; stale response arrives while IDLE
        rst = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h0bad_0bad;
        settle();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h30) begin n_fail++; $display("FAIL rmw_freshreq got %b/%h exp 1/00000030", imem_req, imem_addr); end
        tick();
        // fresh request now in WAIT; the stale word must not have been captured
        imem_rvalid = 1'b0;
        settle();
        n_checks++; if (instr_valid !== 1'b0 || instr !== 32'h0) begin n_fail++; $display("FAIL rmw_stale got v=%b i=%h exp 0/00000000", instr_valid, instr); end
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_600d;
        tick();
        imem_rvalid = 1'b0;
        settle();
        n_checks++; if (instr_valid !== 1'b1 || instr !== 32'h0000_600d || instr_pc !== 32'h30) begin n_fail++; $display("FAIL rmw_fresh got v=%b i=%h pc=%h exp 1/0000600d/00000030", instr_valid, instr, instr_pc); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_backpressure();
        test_flush_wait();
        test_flush_hold();
        test_misaligned();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
